// File: rtl/digiota_comparator_array_pkg.sv
// Shared types and defaults for the clocked comparator array.
package digiota_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_STROBE = 1'b1;

   localparam int unsigned DEF_CHANNELS    = 4;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_FILT_W      = 3;
   localparam int unsigned DEF_TIMEOUT     = 255;

endpackage

// File: rtl/digiota_comparator_array_if.sv
// Pad-side control/data bundle of the comparator array.
interface digiota_comparator_array_if
   import digiota_pkg::*;
#(
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   parameter int unsigned FILT_W   = DEF_FILT_W
);
   logic                en;
   logic                mode;
   logic                strobe;
   logic [FILT_W-1:0]   filt_len;
   logic [CHANNELS-1:0] vip;
   logic [CHANNELS-1:0] vin;
   logic [CHANNELS-1:0] out;
   logic [CHANNELS-1:0] out_oe;
   logic                out_valid;
   logic                done;

   modport master (
      output en, mode, strobe, filt_len, vip, vin,
      input  out, out_oe, out_valid, done
   );

   modport slave (
      input  en, mode, strobe, filt_len, vip, vin,
      output out, out_oe, out_valid, done
   );
endinterface

// File: rtl/digiota_comparator_array_chan_filter.sv
// One comparator channel: input synchroniser, run-length deglitch filter
// and the committed decision / drive-enable register.
module digiota_chan_filter
   import digiota_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned FILT_W      = DEF_FILT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vip,
   input  logic              vin,
   input  logic              clear,
   input  logic              cnt_clr,
   input  logic              commit_allow,
   input  logic [FILT_W-1:0] filt_len,
   output logic              out,
   output logic              out_oe,
   output logic              commit
);
   localparam logic [FILT_W:0] ONE     = {{FILT_W{1'b0}}, 1'b1};
   localparam logic [FILT_W:0] CNT_MAX = {1'b0, {FILT_W{1'b1}}};

   logic [SYNC_STAGES-1:0] vip_sync;
   logic [SYNC_STAGES-1:0] vin_sync;
   logic                   ps;
   logic                   ns;
   logic                   diff;
   logic                   cand;
   logic [FILT_W-1:0]      cnt;
   logic [FILT_W-1:0]      cnt_nx;
   logic [FILT_W:0]        run;
   logic [FILT_W:0]        flen_eff;

   assign ps   = vip_sync[SYNC_STAGES-1];
   assign ns   = vin_sync[SYNC_STAGES-1];
   assign diff = ps ^ ns;

   // Synchronisers run regardless of enable so the data is clean on re-enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vip_sync <= '0;
         vin_sync <= '0;
      end else begin
         vip_sync <= {vip_sync[SYNC_STAGES-2:0], vip};
         vin_sync <= {vin_sync[SYNC_STAGES-2:0], vin};
      end
   end

   // Run length including this cycle, commit decision and saturated count.
   always_comb begin
      run      = '0;
      flen_eff = (filt_len == '0) ? ONE : {1'b0, filt_len};
      if (diff) begin
         if ((ps == cand) && (cnt != '0)) run = {1'b0, cnt} + ONE;
         else                             run = ONE;
      end
      commit = commit_allow && diff && (run >= flen_eff);
      cnt_nx = (run > CNT_MAX) ? CNT_MAX[FILT_W-1:0] : run[FILT_W-1:0];
   end

   // Filter state and committed decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         cand   <= 1'b0;
         out    <= 1'b0;
         out_oe <= 1'b0;
      end else if (clear) begin
         cnt    <= '0;
         cand   <= 1'b0;
         out    <= 1'b0;
         out_oe <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt_nx;
         if (diff) cand <= ps;
         if (commit) begin
            out    <= ps;
            out_oe <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/digiota_comparator_array.sv
// Multi-channel clocked comparator: continuous or strobed one-shot
// conversions with a done pulse and timeout.
module digiota_comparator_array
   import digiota_pkg::*;
#(
   parameter int unsigned CHANNELS    = DEF_CHANNELS,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned FILT_W      = DEF_FILT_W,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   digiota_comparator_array_if.slave   bus
);
   localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   state_t              state;
   state_t              state_nx;
   logic [TW-1:0]       tmo_cnt;
   logic [CHANNELS-1:0] decided;
   logic [CHANNELS-1:0] decided_nx;
   logic [CHANNELS-1:0] commit;
   logic [CHANNELS-1:0] chan_out;
   logic [CHANNELS-1:0] chan_oe;
   logic [CHANNELS-1:0] oe_nx;
   logic                commit_allow;
   logic                start;
   logic                out_valid_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      digiota_chan_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .vip          (bus.vip[g]),
         .vin          (bus.vin[g]),
         .clear        (~bus.en),
         .cnt_clr      (start),
         .commit_allow (commit_allow),
         .filt_len     (bus.filt_len),
         .out          (chan_out[g]),
         .out_oe       (chan_oe[g]),
         .commit       (commit[g])
      );
   end

   assign decided_nx    = decided | commit;
   assign oe_nx         = chan_oe | commit;
   assign bus.out       = chan_out;
   assign bus.out_oe    = chan_oe;
   assign bus.out_valid = out_valid_q;
   assign bus.done      = (state == DONE);

   // Next-state and commit gating; IDLE in continuous mode commits freely.
   always_comb begin
      state_nx     = state;
      commit_allow = 1'b0;
      start        = 1'b0;
      case (state)
         IDLE: begin
            commit_allow = (bus.mode == MODE_CONT);
            if (bus.strobe && (bus.mode == MODE_STROBE)) begin
               start    = 1'b1;
               state_nx = CONVERT;
            end
         end
         CONVERT: begin
            commit_allow = 1'b1;
            if ((&decided_nx) || (tmo_cnt == TMO_LAST)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (!bus.en) begin
         state_nx     = IDLE;
         commit_allow = 1'b0;
         start        = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Timeout counter, per-conversion decided mask and out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt     <= '0;
         decided     <= '0;
         out_valid_q <= 1'b0;
      end else if (!bus.en) begin
         tmo_cnt     <= '0;
         decided     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tmo_cnt     <= '0;
                  decided     <= '0;
                  out_valid_q <= 1'b0;
               end else if (bus.mode == MODE_CONT) begin
                  out_valid_q <= &oe_nx;
               end
            end
            CONVERT: begin
               decided <= decided_nx;
               if (state_nx == DONE) out_valid_q <= &decided_nx;
               else                  tmo_cnt     <= tmo_cnt + TW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_digiota_comparator_array.sv
// Directed + randomized bench for digiota_comparator_array with a
// behavioural per-cycle reference model.
module tb_digiota_comparator_array;
   import digiota_pkg::*;

   localparam int unsigned CH = 4;
   localparam int unsigned SS = 2;
   localparam int unsigned FW = 3;
   localparam int unsigned TO = 255;

   logic clk;
   logic rst_n;

   digiota_comparator_array_if #(.CHANNELS(CH), .FILT_W(FW)) bus ();

   digiota_comparator_array #(
      .CHANNELS    (CH),
      .SYNC_STAGES (SS),
      .FILT_W      (FW),
      .TIMEOUT     (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state: input delay history, run lengths, decisions,
   // and conversion phase (0 idle, 1 converting, 2 done).
   bit hp [CH][SS];
   bit hn [CH][SS];
   int run_len [CH];
   bit run_dir [CH];
   bit m_out [CH];
   bit m_oe [CH];
   bit m_dec [CH];
   bit m_valid;
   int m_phase;
   int m_k;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [CH-1:0] pack(input bit v [CH]);
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++) r[i] = v[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         for (int s = 0; s < SS; s++) begin
            hp[c][s] = 1'b0;
            hn[c][s] = 1'b0;
         end
         run_len[c] = 0;
         run_dir[c] = 1'b0;
         m_out[c]   = 1'b0;
         m_oe[c]    = 1'b0;
         m_dec[c]   = 1'b0;
      end
      m_valid = 1'b0;
      m_phase = 0;
      m_k     = 0;
   endtask

   task automatic model_edge();
      bit ps, ns, allow, start, all_oe, all_dec;
      bit com [CH];
      int flen;
      if (!rst_n) begin
         model_reset();
         return;
      end
      flen = (bus.filt_len == 0) ? 1 : int'(bus.filt_len);
      if (!bus.en) begin
         for (int c = 0; c < CH; c++) begin
            run_len[c] = 0;
            run_dir[c] = 1'b0;
            m_out[c]   = 1'b0;
            m_oe[c]    = 1'b0;
            m_dec[c]   = 1'b0;
         end
         m_valid = 1'b0;
         m_phase = 0;
         m_k     = 0;
      end else begin
         allow = (m_phase == 0) ? !bus.mode : (m_phase == 1);
         start = (m_phase == 0) && bus.mode && bus.strobe;
         for (int c = 0; c < CH; c++) begin
            ps     = hp[c][SS-1];
            ns     = hn[c][SS-1];
            com[c] = 1'b0;
            if (ps != ns) begin
               if (run_len[c] > 0 && run_dir[c] == ps) run_len[c]++;
               else begin
                  run_len[c] = 1;
                  run_dir[c] = ps;
               end
               com[c] = allow && (run_len[c] >= flen);
               if (com[c]) begin
                  m_out[c] = ps;
                  m_oe[c]  = 1'b1;
               end
            end else begin
               run_len[c] = 0;
            end
            if (start) run_len[c] = 0;
         end
         all_oe = 1'b1;
         for (int c = 0; c < CH; c++) all_oe &= m_oe[c];
         case (m_phase)
            0: begin
               if (start) begin
                  m_phase = 1;
                  m_k     = 0;
                  m_valid = 1'b0;
                  for (int c = 0; c < CH; c++) m_dec[c] = 1'b0;
               end else if (!bus.mode) begin
                  m_valid = all_oe;
               end
            end
            1: begin
               all_dec = 1'b1;
               for (int c = 0; c < CH; c++) begin
                  m_dec[c] |= com[c];
                  all_dec  &= m_dec[c];
               end
               if (all_dec || m_k == int'(TO) - 1) begin
                  m_valid = all_dec;
                  m_phase = 2;
               end else begin
                  m_k++;
               end
            end
            default: m_phase = 0;
         endcase
      end
      for (int c = 0; c < CH; c++) begin
         for (int s = SS - 1; s > 0; s--) begin
            hp[c][s] = hp[c][s-1];
            hn[c][s] = hn[c][s-1];
         end
         hp[c][0] = bus.vip[c];
         hn[c][0] = bus.vin[c];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("out",       32'(bus.out),       32'(pack(m_out)));
      chk("out_oe",    32'(bus.out_oe),    32'(pack(m_oe)));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("done",      32'(bus.done),      32'(m_phase == 2));
   endtask

   int done_at;
   int pulses;

   initial begin
      model_reset();
      rst_n        = 1'b0;
      bus.en       = 1'b0;
      bus.mode     = MODE_CONT;
      bus.strobe   = 1'b0;
      bus.filt_len = 3'd3;
      bus.vip      = '0;
      bus.vin      = '0;

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         bus.vip    = CH'($urandom);
         bus.vin    = CH'($urandom);
         bus.en     = 1'($urandom);
         bus.mode   = 1'($urandom);
         bus.strobe = 1'($urandom);
         tick();
      end
      chk("rst_out",   32'(bus.out),       32'd0);
      chk("rst_oe",    32'(bus.out_oe),    32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);

      // Continuous latency: filt_len=3 -> commit on edge 5.
      rst_n        = 1'b1;
      bus.en       = 1'b1;
      bus.mode     = MODE_CONT;
      bus.strobe   = 1'b0;
      bus.filt_len = 3'd3;
      bus.vip      = 4'b0001;
      bus.vin      = 4'b0000;
      repeat (4) tick();
      chk("lat_pre_oe", 32'(bus.out_oe[0]), 32'd0);
      tick();
      chk("lat_out", 32'(bus.out[0]),    32'd1);
      chk("lat_oe",  32'(bus.out_oe[0]), 32'd1);

      // Two-cycle opposite glitch must not flip the decision.
      bus.vip = 4'b0000;
      bus.vin = 4'b0001;
      repeat (2) tick();
      bus.vip = 4'b0001;
      bus.vin = 4'b0000;
      repeat (8) tick();
      chk("glitch_out", 32'(bus.out[0]), 32'd1);

      // Equal inputs hold.
      bus.vip = 4'b1111;
      bus.vin = 4'b1111;
      repeat (20) tick();
      chk("hold_out", 32'(bus.out),    32'h1);
      chk("hold_oe",  32'(bus.out_oe), 32'h1);

      // All four channels decide 1 -> out_valid.
      bus.vip = 4'b1111;
      bus.vin = 4'b0000;
      repeat (6) tick();
      chk("all_valid", 32'(bus.out_valid), 32'd1);
      chk("all_out",   32'(bus.out),       32'hF);

      // Randomized continuous traffic.
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.vip = CH'($urandom);
            bus.vin = CH'($urandom);
         end
         if ($urandom_range(0, 15) == 0) bus.filt_len = FW'($urandom);
         tick();
      end

      // Randomized strobe traffic, then clear via enable.
      bus.mode = MODE_STROBE;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            bus.vip = CH'($urandom);
            bus.vin = CH'($urandom);
         end
         bus.strobe = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) bus.filt_len = FW'($urandom);
         tick();
      end
      bus.strobe = 1'b0;
      bus.en     = 1'b0;
      tick();
      bus.en     = 1'b1;

      // Strobe conversion, filt_len=1, inputs already settled.
      bus.filt_len = 3'd1;
      bus.vip      = 4'b1010;
      bus.vin      = 4'b0101;
      repeat (4) tick();
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
      done_at = -1;
      pulses  = 0;
      for (int i = 2; i <= 20; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            pulses++;
            if (done_at < 0) done_at = i;
         end
      end
      chk("s1_done_at", 32'(done_at),       32'd2);
      chk("s1_pulses",  32'(pulses),        32'd1);
      chk("s1_valid",   32'(bus.out_valid), 32'd1);
      chk("s1_out",     32'(bus.out),       32'hA);

      // Longer conversion with extra strobes in CONVERT and DONE.
      bus.filt_len = 3'd5;
      bus.vip      = 4'b0101;
      bus.vin      = 4'b1010;
      repeat (3) tick();
      bus.strobe = 1'b1;
      tick();
      done_at = -1;
      pulses  = 0;
      for (int i = 2; i <= 25; i++) begin
         bus.strobe = (i == 3 || i == 5 || i == 7);
         tick();
         if (bus.done === 1'b1) begin
            pulses++;
            if (done_at < 0) done_at = i;
         end
      end
      bus.strobe = 1'b0;
      chk("s2_done_at", 32'(done_at),       32'd6);
      chk("s2_pulses",  32'(pulses),        32'd1);
      chk("s2_valid",   32'(bus.out_valid), 32'd1);
      chk("s2_out",     32'(bus.out),       32'h5);

      // Timeout: ch3 equal, others decide.
      bus.en = 1'b0;
      tick();
      bus.en       = 1'b1;
      bus.filt_len = 3'd2;
      bus.vip      = 4'b1001;
      bus.vin      = 4'b1110;
      repeat (4) tick();
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
      done_at = -1;
      for (int i = 2; i <= int'(TO) + 10; i++) begin
         tick();
         if (bus.done === 1'b1 && done_at < 0) done_at = i;
      end
      chk("to_done_at", 32'(done_at),       32'(TO + 1));
      chk("to_valid",   32'(bus.out_valid), 32'd0);
      chk("to_oe3",     32'(bus.out_oe[3]), 32'd0);
      chk("to_out",     32'(bus.out[2:0]),  32'h1);

      // Enable dropped mid-conversion.
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
      repeat (5) tick();
      bus.en = 1'b0;
      tick();
      chk("en_out",   32'(bus.out),       32'd0);
      chk("en_oe",    32'(bus.out_oe),    32'd0);
      chk("en_valid", 32'(bus.out_valid), 32'd0);
      chk("en_state", 32'(dut.state),     32'(IDLE));
      bus.en  = 1'b1;
      bus.vip = 4'b1100;
      bus.vin = 4'b0011;
      repeat (3) tick();
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
      done_at = -1;
      for (int i = 2; i <= 20; i++) begin
         tick();
         if (bus.done === 1'b1 && done_at < 0) done_at = i;
      end
      chk("re_done_at", 32'(done_at),       32'd3);
      chk("re_valid",   32'(bus.out_valid), 32'd1);
      chk("re_out",     32'(bus.out),       32'hC);

      // Asynchronous reset between edges during CONVERT.
      bus.vip = 4'b0000;
      bus.vin = 4'b0000;
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
      repeat (3) tick();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_out",   32'(bus.out),       32'd0);
      chk("arst_oe",    32'(bus.out_oe),    32'd0);
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_done",  32'(bus.done),      32'd0);
      chk("arst_state", 32'(dut.state),     32'(IDLE));
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
